// File: rtl/uart_host_ctrl.sv
// uart_host_ctrl: turns 'W'/'R' command frames from the UART receiver into
// single-byte debug-bus accesses and queues a one-byte response for the
// UART transmitter. Handles inter-byte timeout, unknown commands and
// bytes that arrive while a frame is still being serviced.
module uart_host_ctrl #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int TIMEOUT_US = 1000,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  input  logic              bus_ack,
  input  logic [7:0]        bus_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              err_cmd,
  output logic              err_timeout,
  output logic              err_overrun
);

  localparam int TIMEOUT_CYC = (CLK_FREQ / 1_000_000) * TIMEOUT_US;
  localparam int CNT_W       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR_H = 3'd1,
    ADDR_L = 3'd2,
    DATA   = 3'd3,
    BUS    = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [7:0]        bus_wdata_q, bus_wdata_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              busy_q, busy_d;
  logic              err_cmd_q, err_cmd_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_overrun_q, err_overrun_d;

  // State, timeout counter and every output are registered; reset clears all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= CNT_ZERO;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= {ADDR_W{1'b0}};
      bus_wdata_q   <= 8'h00;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      err_cmd_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      busy_q        <= busy_d;
      err_cmd_q     <= err_cmd_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  // Frame parser, bus handshake and response handshake; errors are one-cycle pulses.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bus_req_d     = bus_req_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    err_cmd_d     = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = CNT_ZERO;
        if (rx_valid) begin
          if (rx_data == CMD_WRITE) begin
            state_d  = ADDR_H;
            bus_we_d = 1'b1;
          end else if (rx_data == CMD_READ) begin
            state_d  = ADDR_H;
            bus_we_d = 1'b0;
          end else begin
            state_d    = RESP;
            tx_data_d  = RSP_NAK;
            tx_valid_d = 1'b1;
            err_cmd_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      ADDR_H, ADDR_L, DATA: begin
        if (rx_valid) begin
          // A byte on the expiry cycle still counts: acceptance beats timeout.
          cnt_d = CNT_ZERO;
          case (state_q)
            ADDR_H: begin
              bus_addr_d[15:8] = rx_data;
              state_d          = ADDR_L;
            end
            ADDR_L: begin
              bus_addr_d[7:0] = rx_data;
              if (bus_we_q) begin
                state_d = DATA;
              end else begin
                state_d   = BUS;
                bus_req_d = 1'b1;
              end
            end
            default: begin
              bus_wdata_d = rx_data;
              state_d     = BUS;
              bus_req_d   = 1'b1;
            end
          endcase
        end else if (cnt_q == CNT_LAST) begin
          cnt_d         = CNT_ZERO;
          state_d       = IDLE;
          err_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      BUS: begin
        err_overrun_d = rx_valid;
        if (bus_ack) begin
          bus_req_d  = 1'b0;
          state_d    = RESP;
          tx_valid_d = 1'b1;
          tx_data_d  = bus_we_q ? RSP_ACK : bus_rdata;
        end else begin
          bus_req_d = 1'b1;
        end
      end

      RESP: begin
        err_overrun_d = rx_valid;
        if (tx_ready) begin
          state_d    = IDLE;
          tx_valid_d = 1'b0;
        end else begin
          tx_valid_d = 1'b1;
        end
      end

      default: begin
        state_d    = IDLE;
        bus_req_d  = 1'b0;
        tx_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign busy        = busy_q;
  assign err_cmd     = err_cmd_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_host_ctrl.sv
// tb_uart_host_ctrl: table-driven frames, directed corner cases and a
// randomized episode stream checked against a transaction-level model.
module tb_uart_host_ctrl;

  localparam int TO = 10;  // timeout cycles at 1 MHz / 10 us

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        bus_req;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_ack;
  logic [7:0]  bus_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        err_cmd;
  logic        err_timeout;
  logic        err_overrun;

  always #5 clk = ~clk;

  uart_host_ctrl #(
    .CLK_FREQ(1_000_000), .TIMEOUT_US(TO), .ADDR_W(16)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .err_cmd(err_cmd), .err_timeout(err_timeout),
    .err_overrun(err_overrun)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Event counters sampled mid-cycle: error pulse cycles and bus requests.
  int   mon_cmd = 0, mon_to = 0, mon_ovr = 0, mon_req = 0, mon_multi = 0;
  logic req_prev = 1'b0;
  always @(negedge clk) begin
    if (err_cmd === 1'b1) mon_cmd++;
    if (err_timeout === 1'b1) mon_to++;
    if (err_overrun === 1'b1) mon_ovr++;
    if ((int'(err_cmd) + int'(err_timeout) + int'(err_overrun)) > 1) mon_multi++;
    if (bus_req === 1'b1 && req_prev !== 1'b1) mon_req++;
    req_prev = bus_req;
  end

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          ack_dly;
    int          rdy_dly;
    logic [7:0]  exp_tx;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    send_byte(v.wr ? 8'h57 : 8'h52);
    check("frm_busy", busy, 1'b1);
    send_byte(v.addr[15:8]);
    send_byte(v.addr[7:0]);
    if (v.wr) begin
      check("frm_no_early_req", bus_req, 1'b0);
      send_byte(v.wdata);
    end
    check("frm_req", bus_req, 1'b1);
    check("frm_we", bus_we, v.wr);
    check("frm_addr", bus_addr, v.addr);
    if (v.wr) check("frm_wdata", bus_wdata, v.wdata);
    for (int d = 0; d < v.ack_dly; d++) begin
      step();
      check("frm_req_hold", {bus_req, bus_we, bus_addr}, {1'b1, v.wr, v.addr});
    end
    bus_rdata = v.rdata;
    bus_ack   = 1'b1;
    step();
    bus_ack   = 1'b0;
    bus_rdata = 8'hEE;
    check("frm_req_drop", bus_req, 1'b0);
    check("frm_tx_valid", tx_valid, 1'b1);
    check("frm_tx_data", tx_data, v.exp_tx);
    for (int r = 0; r < v.rdy_dly; r++) begin
      step();
      check("frm_tx_hold", {tx_valid, tx_data}, {1'b1, v.exp_tx});
    end
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    check("frm_tx_done", tx_valid, 1'b0);
    check("frm_idle", busy, 1'b0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          s_cmd, s_to, s_ovr, s_req;
    int          e_cmd, e_to, e_ovr, e_req;
    int          kind, nb, gap, dly;
    bit          aborted, do_resp;
    logic [7:0]  bytes [4];
    logic [7:0]  exp_tx, rd, b;
    logic [15:0] a;

    vecs[0] = '{wr: 1'b1, addr: 16'h1234, wdata: 8'hAB, rdata: 8'h00, ack_dly: 3, rdy_dly: 2, exp_tx: 8'h06};
    vecs[1] = '{wr: 1'b0, addr: 16'h8001, wdata: 8'h00, rdata: 8'h5A, ack_dly: 0, rdy_dly: 1, exp_tx: 8'h5A};
    vecs[2] = '{wr: 1'b1, addr: 16'hFFFF, wdata: 8'h00, rdata: 8'h33, ack_dly: 0, rdy_dly: 0, exp_tx: 8'h06};
    vecs[3] = '{wr: 1'b0, addr: 16'h0000, wdata: 8'h00, rdata: 8'hFF, ack_dly: 5, rdy_dly: 0, exp_tx: 8'hFF};

    rx_data = 8'h00; rx_valid = 1'b0; bus_ack = 1'b0; bus_rdata = 8'h00;
    tx_ready = 1'b0; rst = 1'b1;
    step();
    step();
    check("rst_bus", {bus_req, bus_we, bus_addr, bus_wdata}, 26'h0);
    check("rst_tx", {tx_valid, tx_data, busy}, 10'h0);
    check("rst_err", {err_cmd, err_timeout, err_overrun}, 3'h0);
    rst = 1'b0;
    step();

    // Table-driven frames.
    for (int i = 0; i < 4; i++) run_frame(vecs[i]);

    // Unknown command: NAK, single-cycle err_cmd, held response, no bus access.
    s_req = mon_req;
    send_byte(8'h41);
    check("nak_err", err_cmd, 1'b1);
    check("nak_tx", {tx_valid, tx_data}, {1'b1, 8'h15});
    check("nak_busy", busy, 1'b1);
    step();
    check("nak_err_pulse", err_cmd, 1'b0);
    idle(3);
    check("nak_hold", tx_valid, 1'b1);
    check("nak_no_req", mon_req - s_req, 0);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    check("nak_done", {tx_valid, busy}, 2'b00);

    // Stray ack while idle is ignored.
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    check("stray_ack", {busy, bus_req, tx_valid}, 3'b000);

    // Timeout after exactly TO silent cycles.
    s_req = mon_req;
    send_byte(8'h57);
    send_byte(8'h00);
    idle(TO - 1);
    check("to_not_yet", {busy, err_timeout}, 2'b10);
    step();
    check("to_fire", {busy, err_timeout}, 2'b01);
    step();
    check("to_pulse", err_timeout, 1'b0);
    check("to_no_req", mon_req - s_req, 0);

    // Byte on the expiry cycle is accepted.
    send_byte(8'h52);
    send_byte(8'h80);
    idle(TO - 1);
    send_byte(8'h01);
    check("exp_accept", {err_timeout, bus_req, bus_addr}, {1'b0, 1'b1, 16'h8001});
    bus_rdata = 8'h5A;
    bus_ack   = 1'b1;
    step();
    bus_ack   = 1'b0;
    check("exp_tx", {tx_valid, tx_data}, {1'b1, 8'h5A});
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    check("exp_done", busy, 1'b0);

    // Overrun in BUS and in RESP.
    send_byte(8'h57); send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB);
    send_byte(8'h99);
    check("ovr_bus", {err_overrun, bus_req, bus_addr, bus_wdata}, {1'b1, 1'b1, 16'h1234, 8'hAB});
    step();
    check("ovr_bus_pulse", err_overrun, 1'b0);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    send_byte(8'h77);
    check("ovr_resp", {err_overrun, tx_valid, tx_data}, {1'b1, 1'b1, 8'h06});
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    check("ovr_done", {tx_valid, busy, err_overrun}, 3'b000);
    run_frame(vecs[1]);

    // Asynchronous reset while bus_req is high.
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
    check("rstm_req", bus_req, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    check("rstm_async", {bus_req, busy, tx_valid}, 3'b000);
    step();
    rst = 1'b0;
    step();
    run_frame(vecs[3]);

    // Randomized episodes against a transaction-level model.
    for (int ep = 0; ep < 150; ep++) begin
      s_cmd = mon_cmd; s_to = mon_to; s_ovr = mon_ovr; s_req = mon_req;
      e_cmd = 0; e_to = 0; e_ovr = 0; e_req = 0;
      aborted = 1'b0; do_resp = 1'b0; exp_tx = 8'h00;
      kind = $urandom_range(0, 2);
      a = 16'($urandom_range(0, 65535));
      bytes[1] = a[15:8];
      bytes[2] = a[7:0];
      bytes[3] = 8'($urandom_range(0, 255));
      if (kind == 0) begin
        bytes[0] = 8'h57; nb = 4;
      end else if (kind == 1) begin
        bytes[0] = 8'h52; nb = 3;
      end else begin
        do b = 8'($urandom_range(0, 255)); while (b == 8'h57 || b == 8'h52);
        bytes[0] = b; nb = 1;
      end

      send_byte(bytes[0]);
      if (kind == 2) begin
        e_cmd = 1; exp_tx = 8'h15; do_resp = 1'b1;
      end else begin
        for (int i = 1; i < nb; i++) begin
          gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO + 2) : $urandom_range(0, 2);
          idle(gap);
          if (gap >= TO) begin
            aborted = 1'b1;
            e_to = 1;
            break;
          end
          send_byte(bytes[i]);
        end
        if (!aborted) begin
          e_req = 1;
          check("rnd_req", {bus_req, bus_we, bus_addr}, {1'b1, kind == 0, a});
          if (kind == 0) check("rnd_wdata", bus_wdata, bytes[3]);
          dly = $urandom_range(0, 4);
          for (int d = 0; d <= dly; d++) begin
            if ($urandom_range(0, 3) == 0) begin
              rx_data = 8'($urandom_range(0, 255)); rx_valid = 1'b1; e_ovr++;
            end
            rd = 8'($urandom_range(0, 255));
            if (d == dly) begin
              bus_ack = 1'b1; bus_rdata = rd;
            end
            step();
            rx_valid = 1'b0; bus_ack = 1'b0;
            if (d < dly) check("rnd_req_hold", {bus_req, bus_addr}, {1'b1, a});
          end
          check("rnd_req_drop", bus_req, 1'b0);
          exp_tx  = (kind == 0) ? 8'h06 : rd;
          do_resp = 1'b1;
        end
      end

      if (do_resp) begin
        check("rnd_tx", {tx_valid, tx_data}, {1'b1, exp_tx});
        dly = $urandom_range(0, 3);
        for (int r = 0; r <= dly; r++) begin
          if ($urandom_range(0, 3) == 0) begin
            rx_data = 8'($urandom_range(0, 255)); rx_valid = 1'b1; e_ovr++;
          end
          tx_ready = (r == dly);
          step();
          rx_valid = 1'b0; tx_ready = 1'b0;
          if (r < dly) check("rnd_tx_hold", {tx_valid, tx_data}, {1'b1, exp_tx});
        end
        check("rnd_tx_done", tx_valid, 1'b0);
      end

      for (int k = 0; k < 2; k++) begin
        bus_ack = 1'($urandom_range(0, 1));
        step();
        bus_ack = 1'b0;
      end
      check("rnd_idle", {busy, bus_req, tx_valid}, 3'b000);
      check("rnd_cmd_cnt", mon_cmd - s_cmd, e_cmd);
      check("rnd_to_cnt", mon_to - s_to, e_to);
      check("rnd_ovr_cnt", mon_ovr - s_ovr, e_ovr);
      check("rnd_req_cnt", mon_req - s_req, e_req);
    end

    check("multi_err", mon_multi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_host_ctrl.md
Name: uart_host_ctrl

Overview:
- Host-command sequencer behind the UART receiver.
- Consumes the received byte stream and parses 3- or 4-byte command frames.
- Runs one single-byte read or write on the board's debug bus per frame, then queues a one-byte response to the UART transmitter.
- Owns frame timeout, unknown-command handling and overrun detection for the host link.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- TIMEOUT_US, 1000, maximum gap in microseconds between bytes of one frame.
- ADDR_W, 16, bus address width. Must be 16 for the two-byte address frame.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle. There is no backpressure.
- bus_req  out  1  bus request, held until acknowledged.
- bus_we  out  1  1 = write, 0 = read; stable while bus_req is high.
- bus_addr  out  ADDR_W  bus address; stable while bus_req is high.
- bus_wdata  out  8  write data; stable while bus_req is high.
- bus_ack  in  1  one-cycle completion strobe from the bus.
- bus_rdata  in  8  read data; valid when bus_ack=1 and bus_we=0.
- tx_data  out  8  response byte to the UART transmitter.
- tx_valid  out  1  response valid; held until tx_ready.
- tx_ready  in  1  transmitter can accept a byte.
- busy  out  1  high whenever state is not IDLE.
- err_cmd  out  1  one-cycle pulse: unknown command byte.
- err_timeout  out  1  one-cycle pulse: frame abandoned on inter-byte timeout.
- err_overrun  out  1  one-cycle pulse: byte arrived in BUS or RESP and was dropped.

Behaviour:
- Reset: every output is 0, state=IDLE, timeout counter=0, internal registers=0.
- Frame formats:
  - Write: 0x57 'W', addr_hi, addr_lo, data.
  - Read: 0x52 'R', addr_hi, addr_lo.
- States: IDLE, ADDR_H, ADDR_L, DATA, BUS, RESP.
- IDLE, on rx_valid:
  - rx_data=0x57 -> ADDR_H, write flag set.
  - rx_data=0x52 -> ADDR_H, write flag cleared.
  - Any other byte -> RESP with tx_data=0x15 (NAK), err_cmd pulses the same cycle the state changes.
- ADDR_H, on rx_valid: latch bus_addr[15:8], go to ADDR_L.
- ADDR_L, on rx_valid: latch bus_addr[7:0].
  - Write -> DATA.
  - Read -> BUS, bus_req=1 from the next cycle.
- DATA, on rx_valid: latch bus_wdata, go to BUS; bus_req rises on the next cycle.
- BUS:
  - bus_req, bus_we, bus_addr and bus_wdata stay constant until bus_ack is sampled high.
  - On the ack cycle, bus_req drops on the next edge and the state moves to RESP.
  - tx_data = 0x06 (ACK) for a write; tx_data = bus_rdata captured on the ack cycle for a read.
  - bus_ack seen while bus_req=0 is ignored.
- RESP:
  - tx_valid=1 with tx_data stable.
  - On the cycle with tx_valid&&tx_ready, go to IDLE; tx_valid is 0 on the next cycle.
  - Frame latency: bus_req is high 1 cycle after the last frame byte. tx_valid is high 1 cycle after bus_ack.
- Timeout:
  - TIMEOUT_CYC = (CLK_FREQ/1_000_000)*TIMEOUT_US; counter width = $clog2(TIMEOUT_CYC+1).
  - Counter clears on entry to ADDR_H and on every accepted byte, and increments in ADDR_H, ADDR_L and DATA.
  - If the counter reaches TIMEOUT_CYC-1 with no rx_valid in that cycle: go to IDLE, err_timeout pulses, no bus access.
  - An rx_valid in the same cycle as expiry wins: the byte is accepted and the counter clears.
- Overrun: rx_valid during BUS or RESP drops the byte and pulses err_overrun. State and outputs are unaffected.
- Error pulses last exactly one cycle. At most one error fires per cycle (exclusive by state).
- Reset mid-operation: bus_req and tx_valid drop immediately (asynchronous); any partial frame is discarded.

Test Plan:
- Write 0x57,0x12,0x34,0xAB, bus_ack 3 cycles after bus_req -> bus_req=1, bus_we=1, bus_addr=0x1234, bus_wdata=0xAB; then tx_data=0x06 with tx_valid until tx_ready.
- Read 0x52,0x80,0x01, bus_rdata=0x5A on ack -> bus_we=0, bus_addr=0x8001; then tx_data=0x5A; busy returns to 0 after the tx handshake.
- Byte 0x41 in IDLE -> err_cmd pulses 1 cycle, tx_data=0x15, no bus_req; with tx_ready held low, tx_valid stays high.
- CLK_FREQ=1_000_000, TIMEOUT_US=10: send 0x57,0x00 then silence -> err_timeout after 10 idle cycles, state IDLE, bus_req never asserted. A byte arriving on the expiry cycle is accepted.
- Extra rx_valid during BUS and during RESP -> err_overrun pulses each time; bus_addr/tx_data unchanged; the next frame parses correctly.
- Assert rst while bus_req=1 -> bus_req=0, busy=0 immediately; a subsequent read frame completes normally.
